lookup_arb: RTL and testbench

LOOKUP_ARB -- requirements
Module: lookup_arb

---
 rtl/lookup_arb_if.sv | 55 +++++
 rtl/lookup_arb.sv | 136 +++++++++++++
 tb/tb_lookup_arb.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lookup_arb_if.sv
// lookup_arb_if: request/response bundle between two lookup requesters,
// the arbiter and the RAM.
// Parameters: ABITS (RAM address width), DW (RAM data width).
// Request words are W = 1+ABITS+DW bits wide, laid out {write, addr, data}.
// Modports: slave (the arbiter), master (requesters and RAM side).
interface lookup_arb_if #(
    parameter int ABITS = 8,
    parameter int DW    = 32
);
    localparam int W = 1 + ABITS + DW;

    logic          TIE_lookup0_Out_Req;
    logic [W-1:0]  TIE_lookup0_Out;
    logic          TIE_lookup0_Out_Rdy;
    logic [DW-1:0] TIE_lookup0_In;
    logic          TIE_lookup0_In_Valid;
    logic          TIE_lookup0_In_Rdy;

    logic          TIE_lookup1_Out_Req;
    logic [W-1:0]  TIE_lookup1_Out;
    logic          TIE_lookup1_Out_Rdy;
    logic [DW-1:0] TIE_lookup1_In;
    logic          TIE_lookup1_In_Valid;
    logic          TIE_lookup1_In_Rdy;

    logic          TIE_lookup_ram_Out_Req;
    logic [W-1:0]  TIE_lookup_ram_Out;
    logic [DW-1:0] TIE_lookup_ram_In;

    modport slave (
        input  TIE_lookup0_Out_Req, TIE_lookup0_Out,
        input  TIE_lookup0_In_Rdy,
        output TIE_lookup0_Out_Rdy, TIE_lookup0_In,
        output TIE_lookup0_In_Valid,
        input  TIE_lookup1_Out_Req, TIE_lookup1_Out,
        input  TIE_lookup1_In_Rdy,
        output TIE_lookup1_Out_Rdy, TIE_lookup1_In,
        output TIE_lookup1_In_Valid,
        output TIE_lookup_ram_Out_Req, TIE_lookup_ram_Out,
        input  TIE_lookup_ram_In
    );

    modport master (
        output TIE_lookup0_Out_Req, TIE_lookup0_Out,
        output TIE_lookup0_In_Rdy,
        input  TIE_lookup0_Out_Rdy, TIE_lookup0_In,
        input  TIE_lookup0_In_Valid,
        output TIE_lookup1_Out_Req, TIE_lookup1_Out,
        output TIE_lookup1_In_Rdy,
        input  TIE_lookup1_Out_Rdy, TIE_lookup1_In,
        input  TIE_lookup1_In_Valid,
        input  TIE_lookup_ram_Out_Req, TIE_lookup_ram_Out,
        output TIE_lookup_ram_In
    );
endinterface

// File: rtl/lookup_arb.sv
// lookup_arb: two-requester arbiter in front of a single-port RAM with
// registered request strobe and a per-requester read response FSM.
// Ports: CLK, Reset (async active-high), bus (lookup_arb_if.slave).
// Macro LOOKUP_ARB_RR_EN: round-robin on contention; otherwise req0 wins.
module lookup_arb #(
    parameter int ABITS = 8,
    parameter int DW    = 32
) (
    input  logic CLK,
    input  logic Reset,
    lookup_arb_if.slave bus
);
    localparam int W = 1 + ABITS + DW;

    typedef enum logic [1:0] {
        IDLE,
        ISSUED,
        WAIT,
        FULL
    } resp_e;

    resp_e         state    [2];
    resp_e         state_nx [2];
    logic [DW-1:0] resp     [2];
    logic [W-1:0]  word     [2];
    logic [1:0]    req;
    logic [1:0]    rdy_in;
    logic [1:0]    wr;
    logic [1:0]    elig;
    logic [1:0]    grant;
    logic          prio;
    logic          ram_req_q;
    logic [W-1:0]  ram_word_q;

    assign req     = {bus.TIE_lookup1_Out_Req, bus.TIE_lookup0_Out_Req};
    assign rdy_in  = {bus.TIE_lookup1_In_Rdy, bus.TIE_lookup0_In_Rdy};
    assign word[0] = bus.TIE_lookup0_Out;
    assign word[1] = bus.TIE_lookup1_Out;

    // Writes never produce a response, so they bypass the FSM check.
    always_comb begin
        wr   = 2'b00;
        elig = 2'b00;
        for (int n = 0; n < 2; n++) begin
            wr[n]   = word[n][W-1];
            elig[n] = req[n] && (wr[n] || state[n] == IDLE);
        end
    end

    // prio=1 hands contention to requester 1. Reset gates the grant so
    // Out_Rdy drops immediately while Reset is high.
    always_comb begin
        grant = 2'b00;
        if (!Reset) begin
            if (elig[0] && (!elig[1] || !prio))
                grant = 2'b01;
            else if (elig[1])
                grant = 2'b10;
        end
    end

`ifdef LOOKUP_ARB_RR_EN
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset)
            prio <= 1'b0;
        else if (grant[0])
            prio <= 1'b1;
        else if (grant[1])
            prio <= 1'b0;
    end
`else
    assign prio = 1'b0;
`endif

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            state_nx[n] = state[n];
            case (state[n])
                IDLE:
                    if (grant[n] && !wr[n])
                        state_nx[n] = ISSUED;
                ISSUED:
                    state_nx[n] = WAIT;
                WAIT:
                    state_nx[n] = FULL;
                FULL:
                    if (rdy_in[n])
                        state_nx[n] = IDLE;
                default:
                    state_nx[n] = IDLE;
            endcase
        end
    end

    // RAM data is only looked at in WAIT; any other cycle it is ignored.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int n = 0; n < 2; n++) begin
                state[n] <= IDLE;
                resp[n]  <= '0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                state[n] <= state_nx[n];
                if (state[n] == WAIT)
                    resp[n] <= bus.TIE_lookup_ram_In;
            end
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            ram_req_q  <= 1'b0;
            ram_word_q <= '0;
        end else begin
            ram_req_q <= |grant;
            if (grant[0])
                ram_word_q <= word[0];
            else if (grant[1])
                ram_word_q <= word[1];
            else
                ram_word_q <= '0;
        end
    end

    assign bus.TIE_lookup0_Out_Rdy  = grant[0];
    assign bus.TIE_lookup1_Out_Rdy  = grant[1];
    assign bus.TIE_lookup0_In_Valid = (state[0] == FULL);
    assign bus.TIE_lookup1_In_Valid = (state[1] == FULL);
    assign bus.TIE_lookup0_In =
        (state[0] == FULL) ? resp[0] : '0;
    assign bus.TIE_lookup1_In =
        (state[1] == FULL) ? resp[1] : '0;
    assign bus.TIE_lookup_ram_Out_Req = ram_req_q;
    assign bus.TIE_lookup_ram_Out     = ram_word_q;
endmodule

// File: tb/tb_lookup_arb.sv
// tb_lookup_arb: directed and random stimulus for lookup_arb, checked
// against a transaction-level model of arbitration and read responses.
module tb_lookup_arb;
    localparam int ABITS = 8;
    localparam int DW    = 32;
    localparam int W     = 1 + ABITS + DW;

    logic CLK = 1'b0;
    logic Reset;

    lookup_arb_if #(.ABITS(ABITS), .DW(DW)) bus ();

    lookup_arb #(.ABITS(ABITS), .DW(DW)) dut (
        .CLK  (CLK),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] init_val(input int a);
        logic [7:0] b;
        b = a[7:0];
        return {~b, b, 8'h3c, b ^ 8'ha5};
    endfunction

    function automatic logic [W-1:0] mk(input bit w, input int a,
                                        input logic [DW-1:0] d);
        logic [ABITS-1:0] aa;
        aa = a[ABITS-1:0];
        return {w, aa, d};
    endfunction

    // Environment RAM: one-cycle read latency, garbage when not reading.
    logic [DW-1:0] ram     [256];
    bit            ram_wr  [256];
    logic [ABITS-1:0] ram_a;
    assign ram_a = bus.TIE_lookup_ram_Out[W-2 -: ABITS];

    always @(posedge CLK) begin
        if (bus.TIE_lookup_ram_Out_Req && !bus.TIE_lookup_ram_Out[W-1])
            bus.TIE_lookup_ram_In <= ram_wr[ram_a] ? ram[ram_a]
                                                   : init_val(int'(ram_a));
        else
            bus.TIE_lookup_ram_In <= $urandom;
        if (bus.TIE_lookup_ram_Out_Req && bus.TIE_lookup_ram_Out[W-1]) begin
            ram[ram_a]    <= bus.TIE_lookup_ram_Out[DW-1:0];
            ram_wr[ram_a] <= 1'b1;
        end
    end

    logic [1:0]    in_v;
    logic [1:0]    out_rdy;
    logic [DW-1:0] in_d [2];
    assign in_v    = {bus.TIE_lookup1_In_Valid, bus.TIE_lookup0_In_Valid};
    assign out_rdy = {bus.TIE_lookup1_Out_Rdy, bus.TIE_lookup0_Out_Rdy};
    assign in_d[0] = bus.TIE_lookup0_In;
    assign in_d[1] = bus.TIE_lookup1_In;

    // Reference model: a read is outstanding from acceptance until
    // consumed; data is visible from two cycles after acceptance.
    logic [DW-1:0] ref_mem [256];
    bit            out_m   [2];
    int            acc_m   [2];
    logic [DW-1:0] dat_m   [2];
    bit            prio_m;
    bit            exp_rq;
    logic [W-1:0]  exp_rw;
    int            cyc;

    task automatic model_reset();
        out_m[0] = 0;
        out_m[1] = 0;
        prio_m   = 0;
        exp_rq   = 0;
        exp_rw   = '0;
    endtask

    task automatic step(input bit r0, input logic [W-1:0] w0,
                        input bit y0, input bit r1,
                        input logic [W-1:0] w1, input bit y1);
        bit           r  [2];
        bit           y  [2];
        logic [W-1:0] w  [2];
        bit           el [2];
        bit           vis [2];
        int           g;
        int           a;
        r[0] = r0; r[1] = r1;
        y[0] = y0; y[1] = y1;
        w[0] = w0; w[1] = w1;
        @(negedge CLK);
        for (int n = 0; n < 2; n++) begin
            vis[n] = out_m[n] && (cyc >= acc_m[n] + 2);
            chk($sformatf("in_valid%0d", n), 64'(in_v[n]), 64'(vis[n]));
            chk($sformatf("in_data%0d", n), 64'(in_d[n]),
                vis[n] ? 64'(dat_m[n]) : 64'd0);
        end
        chk("ram_req", 64'(bus.TIE_lookup_ram_Out_Req), 64'(exp_rq));
        chk("ram_word", 64'(bus.TIE_lookup_ram_Out), 64'(exp_rw));
        bus.TIE_lookup0_Out_Req = r0;
        bus.TIE_lookup0_Out     = w0;
        bus.TIE_lookup0_In_Rdy  = y0;
        bus.TIE_lookup1_Out_Req = r1;
        bus.TIE_lookup1_Out     = w1;
        bus.TIE_lookup1_In_Rdy  = y1;
        #1;
        for (int n = 0; n < 2; n++)
            el[n] = r[n] && (w[n][W-1] || !out_m[n]);
        g = -1;
        if (el[0] && (!el[1] || !prio_m))
            g = 0;
        else if (el[1])
            g = 1;
        chk("out_rdy0", 64'(out_rdy[0]), 64'(g == 0));
        chk("out_rdy1", 64'(out_rdy[1]), 64'(g == 1));
        for (int n = 0; n < 2; n++)
            if (vis[n] && y[n])
                out_m[n] = 0;
        if (g >= 0) begin
            exp_rq = 1;
            exp_rw = w[g];
            a = int'(w[g][W-2 -: ABITS]);
            if (w[g][W-1]) begin
                ref_mem[a] = w[g][DW-1:0];
            end else begin
                out_m[g] = 1;
                acc_m[g] = cyc + 1;
                dat_m[g] = ref_mem[a];
            end
`ifdef LOOKUP_ARB_RR_EN
            prio_m = (g == 0);
`endif
        end else begin
            exp_rq = 0;
            exp_rw = '0;
        end
        @(posedge CLK);
        cyc++;
    endtask

    task automatic idle(input bit y0, input bit y1);
        step(0, '0, y0, 0, '0, y1);
    endtask

    task automatic rand_step();
        bit r0, r1, y0, y1;
        r0 = ($urandom_range(0, 3) != 0);
        r1 = ($urandom_range(0, 3) != 0);
        y0 = ($urandom_range(0, 2) == 0);
        y1 = ($urandom_range(0, 2) == 0);
        step(r0, mk($urandom_range(0, 1) == 1, $urandom_range(0, 15),
                    $urandom), y0,
             r1, mk($urandom_range(0, 1) == 1, $urandom_range(0, 15),
                    $urandom), y1);
    endtask

    initial begin
        #300000;
        $display("FAIL timeout got running exp finished");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++)
            ref_mem[i] = init_val(i);
        model_reset();
        cyc = 0;
        Reset = 1'b1;
        bus.TIE_lookup0_Out_Req = 1'b1;
        bus.TIE_lookup0_Out     = mk(0, 1, 32'h0);
        bus.TIE_lookup0_In_Rdy  = 1'b0;
        bus.TIE_lookup1_Out_Req = 1'b1;
        bus.TIE_lookup1_Out     = mk(1, 2, 32'h5);
        bus.TIE_lookup1_In_Rdy  = 1'b0;
        #22;
        chk("rst_out_rdy", 64'(out_rdy), 64'd0);
        chk("rst_in_valid", 64'(in_v), 64'd0);
        chk("rst_ram_req", 64'(bus.TIE_lookup_ram_Out_Req), 64'd0);
        chk("rst_ram_word", 64'(bus.TIE_lookup_ram_Out), 64'd0);
        chk("rst_in0", 64'(in_d[0]), 64'd0);
        @(negedge CLK);
        bus.TIE_lookup0_Out_Req = 1'b0;
        bus.TIE_lookup1_Out_Req = 1'b0;
        Reset = 1'b0;

        // single write, then read of the same address by requester 1
        step(1, mk(1, 'h10, 32'h12345678), 0, 0, '0, 0);
        step(0, '0, 0, 1, mk(0, 'h10, 32'h0), 0);
        repeat (4) idle(0, 0);
        idle(0, 1);
        idle(0, 0);

        // contention on writes
        repeat (6)
            step(1, mk(1, 3, $urandom), 0, 1, mk(1, 4, $urandom), 0);
        idle(0, 0);

        // backpressure: req0 FULL and not consuming
        step(1, mk(0, 5, 32'h0), 0, 0, '0, 0);
        repeat (3) idle(0, 0);
        step(1, mk(0, 6, 32'h0), 0, 1, mk(0, 7, 32'h0), 0);
        step(1, mk(1, 6, 32'hcafef00d), 0, 0, '0, 1);
        repeat (3) idle(0, 1);
        idle(1, 1);
        idle(0, 0);
        step(1, mk(0, 6, 32'h0), 1, 0, '0, 0);
        repeat (4) idle(1, 0);

        repeat (2000) rand_step();

        // reset while requester 1's read is in WAIT
        step(0, '0, 0, 1, mk(0, 9, 32'h0), 0);
        idle(0, 0);
        @(negedge CLK);
        bus.TIE_lookup0_Out_Req = 1'b1;
        bus.TIE_lookup0_Out     = mk(0, 2, 32'h0);
        Reset = 1'b1;
        #1;
        chk("mid_rst_out_rdy", 64'(out_rdy), 64'd0);
        chk("mid_rst_in_valid", 64'(in_v), 64'd0);
        chk("mid_rst_in1", 64'(in_d[1]), 64'd0);
        chk("mid_rst_ram_req", 64'(bus.TIE_lookup_ram_Out_Req), 64'd0);
        chk("mid_rst_ram_word", 64'(bus.TIE_lookup_ram_Out), 64'd0);
        bus.TIE_lookup0_Out_Req = 1'b0;
        bus.TIE_lookup0_In_Rdy  = 1'b0;
        bus.TIE_lookup1_In_Rdy  = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        Reset = 1'b0;
        model_reset();
        repeat (5) idle(0, 0);
        repeat (200) rand_step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
